// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one character per valid/ready handshake, serialised as
// start, 7/8 data bits LSB first, optional parity, 1/2 stop bits at a programmable bit rate.
module uart_tx_ctrl #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             d_num,
    input  logic             s_num,
    input  logic [1:0]       par,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt, div_q;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       data_q;
    logic             d_q, s_q;
    logic [1:0]       par_q;
    logic             tx_nxt, done_nxt, load;
    logic [7:0]       data_mask;
    logic             par_bit;

    assign tx_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);

    // In 7-bit mode bit 7 is excluded from the parity calculation.
    assign data_mask = d_q ? data_q : {1'b0, data_q[6:0]};
    assign par_bit   = (par_q == 2'd1) ? ~(^data_mask) : (^data_mask);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        load      = 1'b0;
        tx_nxt    = 1'b1;

        if (state == IDLE) begin
            if (tx_valid) begin
                state_nxt = START;
                cnt_nxt   = baud_div;
                idx_nxt   = '0;
                load      = 1'b1;
            end
        end else if (cnt != '0) begin
            cnt_nxt = cnt - DIV_W'(1);
        end else begin
            cnt_nxt = div_q;
            case (state)
                START: begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                end
                DATA: begin
                    if (idx == (d_q ? 3'd7 : 3'd6)) begin
                        state_nxt = (par_q != 2'd0) ? PARITY : STOP;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
                PARITY: begin
                    state_nxt = STOP;
                    idx_nxt   = '0;
                end
                STOP: begin
                    // idx counts stop bits already sent when two are configured.
                    if (s_q && (idx == 3'd0)) begin
                        idx_nxt = 3'd1;
                    end else begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_q[idx_nxt];
            PARITY:  tx_nxt = par_bit;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            tx     <= 1'b1;
            done   <= 1'b0;
            data_q <= '0;
            d_q    <= 1'b0;
            s_q    <= 1'b0;
            par_q  <= '0;
            div_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            tx    <= tx_nxt;
            done  <= done_nxt;
            if (load) begin
                data_q <= tx_data;
                d_q    <= d_num;
                s_q    <= s_num;
                par_q  <= par;
                div_q  <= baud_div;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a per-cycle waveform model built from frame rules,
// plus hand-computed literal frame captures.
module tb_uart_tx_ctrl;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] baud_div;
    logic             d_num, s_num;
    logic [1:0]       par;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready, tx, busy, done;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic model_ready = 1'b0;

    uart_tx_ctrl #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_div (baud_div),
        .d_num    (d_num),
        .s_num    (s_num),
        .par      (par),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: on accept, expand the frame into one expected entry per clock cycle.
    logic [15:0] fbits;
    int          fn, ones, fdiv;
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else if (tx_valid && model_ready) begin
            fn   = 0;
            ones = 0;
            fbits = '0;
            fbits[fn] = 1'b0; fn++;
            for (int i = 0; i < (d_num ? 8 : 7); i++) begin
                fbits[fn] = tx_data[i];
                ones += int'(tx_data[i]);
                fn++;
            end
            if (par != 2'd0) begin
                fbits[fn] = (par == 2'd1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
                fn++;
            end
            fbits[fn] = 1'b1; fn++;
            if (s_num) begin
                fbits[fn] = 1'b1; fn++;
            end
            fdiv = int'(baud_div);
            for (int b = 0; b < fn; b++)
                for (int c = 0; c <= fdiv; c++)
                    exp_q.push_back('{tx: fbits[b], busy: 1'b1, done: 1'b0});
            exp_q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
        end
    end

    // Compare every cycle once the first edge has established the reset state.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
            checkOutput("tx",       tx,       cur.tx);
            checkOutput("busy",     busy,     cur.busy);
            checkOutput("done",     done,     cur.done);
            checkOutput("tx_ready", tx_ready, !cur.busy && !reset);
            model_ready = !cur.busy && !reset;
        end
    end

    task automatic waitAccept(output int edges);
        bit got = 0;
        edges = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            edges++;
            if (tx_valid && model_ready) got = 1;
        end
        if (!got) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic d, input logic s,
                                 input logic [1:0] p, input int div, input bit hold);
        int e;
        @(posedge clk);
        #2;
        tx_data  = data;
        d_num    = d;
        s_num    = s;
        par      = p;
        baud_div = DIV_W'(div);
        tx_valid = 1'b1;
        waitAccept(e);
        #2;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic captureFrame(input int nbits, input int div, output logic [15:0] bits,
                                output int busy_cnt, output logic done_seen);
        int total;
        total     = nbits * (div + 1);
        bits      = '0;
        busy_cnt  = 0;
        done_seen = 1'b0;
        for (int c = 1; c <= total + 1; c++) begin
            @(negedge clk);
            if (c <= total && ((c - 1) % (div + 1)) == 0) bits[(c - 1) / (div + 1)] = tx;
            if (busy) busy_cnt++;
            if (c == total + 1) done_seen = done;
        end
    endtask

    logic [15:0] bits;
    int          bcnt, edges;
    logic        dseen;

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        d_num    = 1'b1;
        s_num    = 1'b0;
        par      = 2'd0;
        baud_div = '0;

        @(negedge clk);
        checkOutput("reset_tx",       tx,       1);
        checkOutput("reset_busy",     busy,     0);
        checkOutput("reset_done",     done,     0);
        checkOutput("reset_tx_ready", tx_ready, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", tx_ready, 1);

        $display("[TB] 8N1 0x55 div 3");
        applyStimulus(8'h55, 1'b1, 1'b0, 2'd0, 3, 1'b0);
        captureFrame(10, 3, bits, bcnt, dseen);
        checkOutput("8N1_bits", bits, 16'h02AA);
        checkOutput("8N1_busy", bcnt, 40);
        checkOutput("8N1_done", dseen, 1);

        $display("[TB] 7E2 0xC1 div 1");
        applyStimulus(8'hC1, 1'b0, 1'b1, 2'd2, 1, 1'b0);
        captureFrame(11, 1, bits, bcnt, dseen);
        checkOutput("7E2_bits", bits, 16'h0682);
        checkOutput("7E2_busy", bcnt, 22);
        checkOutput("7E2_done", dseen, 1);

        $display("[TB] 8O1 0x00 div 0");
        applyStimulus(8'h00, 1'b1, 1'b0, 2'd1, 0, 1'b0);
        captureFrame(11, 0, bits, bcnt, dseen);
        checkOutput("8O1_bits", bits, 16'h0600);
        checkOutput("8O1_busy", bcnt, 11);
        checkOutput("8O1_done", dseen, 1);

        $display("[TB] back-to-back 0xA5 then 0x3C");
        applyStimulus(8'hA5, 1'b1, 1'b0, 2'd0, 2, 1'b1);
        tx_data = 8'h3C;
        waitAccept(edges);
        checkOutput("b2b_gap_edges", edges, 31);
        #2 tx_valid = 1'b0;
        repeat (35) @(posedge clk);

        $display("[TB] config change mid-frame");
        applyStimulus(8'h96, 1'b1, 1'b0, 2'd0, 2, 1'b0);
        d_num    = 1'b0;
        par      = 2'd2;
        baud_div = '0;
        tx_data  = 8'h12;
        captureFrame(10, 2, bits, bcnt, dseen);
        checkOutput("cfg_old_bits", bits, 16'h032C);
        checkOutput("cfg_old_busy", bcnt, 30);
        applyStimulus(8'h12, 1'b0, 1'b0, 2'd2, 0, 1'b0);
        captureFrame(10, 0, bits, bcnt, dseen);
        checkOutput("cfg_new_bits", bits, 16'h0224);
        checkOutput("cfg_new_busy", bcnt, 10);
        checkOutput("cfg_new_done", dseen, 1);

        $display("[TB] reset during data bit 3");
        applyStimulus(8'h0F, 1'b1, 1'b0, 2'd0, 1, 1'b0);
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_tx",    tx,       1);
        checkOutput("abort_busy",  busy,     0);
        checkOutput("abort_done",  done,     0);
        checkOutput("abort_ready", tx_ready, 1);
        applyStimulus(8'h5A, 1'b1, 1'b0, 2'd0, 1, 1'b0);
        captureFrame(10, 1, bits, bcnt, dseen);
        checkOutput("after_reset_bits", bits, 16'h02B4);
        checkOutput("after_reset_done", dseen, 1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller: accepts one character per valid/ready handshake, latches the line configuration, and serialises the frame onto `tx` at a programmable bit rate. Frames have a start bit, 7 or 8 data bits sent LSB first, optional parity, and 1 or 2 stop bits. Sits between the host-side TX FIFO and the serial pin. It owns the bit-rate divider and bit sequencing for the transmit path.

## Interface
- `DIV_W`, 16: width of the bit-period divisor.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `baud_div`  in  DIV_W  clocks per bit minus 1; bit period = `baud_div`+1 clocks.
- `d_num`  in  1  1 = 8 data bits, 0 = 7 data bits (`tx_data[7]` ignored).
- `s_num`  in  1  1 = two stop bits, 0 = one stop bit.
- `par`  in  2  0 = none, 1 = odd, 2 = even, 3 = even.
- `tx_data`  in  8  character to send.
- `tx_valid`  in  1  `tx_data` and config valid.
- `tx_ready`  out  1  controller can accept a character.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `tx_ready` = (state == IDLE) && !`reset`. Accept = `tx_valid` && `tx_ready` at a rising edge.
- On accept, latch `tx_data`, `d_num`, `s_num`, `par`, `baud_div`. Input changes mid-frame have no effect.
- On accept, go to START, load bit counter = latched `baud_div`, and clear the data index.
- Each bit lasts latched `baud_div`+1 cycles. The counter decrements every cycle. At the edge where it reads 0, the FSM advances to the next bit and reloads the counter.
- START: `tx`=0.
- DATA: `tx` = data[index], index 0 upward. Leaves after index 6 (`d_num`=0) or index 7 (`d_num`=1). Goes to PARITY if `par`≠0, else STOP.
- PARITY: even parity sends XOR of the sent data bits; odd parity sends its inverse. With 7 data bits, only bits [6:0] count.
- STOP: `tx`=1 for one or two bit periods per latched `s_num`, then IDLE.
- `busy` = 1 in every state except IDLE.
- `done` is registered. It is 1 for exactly the cycle after the edge that leaves STOP, which is the first IDLE cycle.
- `tx` is registered (no glitches). It is 1 in IDLE.
- Frame length = 1 + (7|8) + (0|1) + (1|2) bits, i.e. 9 to 12 bit periods.

## Timing
- Reset values (at the first edge with `reset`=1): state IDLE, `tx`=1, `busy`=0, `done`=0, counters 0. `tx_ready`=0 while `reset` is asserted and 1 from the first cycle after.
- Latency: with accept at edge E0, `tx` falls in the cycle following E0.
- A full frame occupies N×(`baud_div`+1) cycles from E0, where N is the bit count.
- Back-to-back: the first IDLE cycle after a frame has `done`=1 and `tx_ready`=1. A character accepted at the end of that cycle gives exactly one extra high cycle between the last stop bit and the next start bit.
- `baud_div`=0: one cycle per bit, and the counter never decrements.
- Reset mid-frame: abort immediately. `tx`=1 the next cycle, no `done` pulse, and the partial frame is dropped.
- `tx_valid` while busy is ignored; the source must hold it until accepted.

## Test plan
- 8N1, `tx_data`=0x55, `baud_div`=3: `tx` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles). `done` is high in cycle 41. `busy` is high for exactly 40 cycles.
- 7E2, `tx_data`=0xC1, `baud_div`=1: data bits 1,0,0,0,0,0,1, parity 0, two stop bits. Frame is 11 bits, 22 cycles. Bit 7 is not sent.
- 8O1, `tx_data`=0x00, `baud_div`=0: start 0, eight 0s, parity 1, stop 1. 11 cycles, then `done`.
- Back-to-back with `tx_valid` held high, 0xA5 then 0x3C, 8N1, `baud_div`=2: second start bit begins exactly 1 cycle after the first frame's stop bit ends. Both characters are sent intact.
- Config/divisor change mid-frame: `d_num`, `par`, and `baud_div` toggled after accept leave the frame unchanged. The next frame uses the new values.
- Reset asserted in DATA bit 3: `tx`=1 and `busy`=0 the next cycle, no `done`. After reset, `tx_ready`=1 and a new 8N1 frame sends correctly.
